truth_table_capture: RTL and testbench
======================================

// Module: truth_table_capture
// PURPOSE
// Response-side companion to our 3-input gate-level combinational function blocks.
// It drives every input combination onto a function-under-test in turn and holds
// each one for a fixed dwell. It then samples the true (f) and complement (fn)
// outputs and rebuilds the function's minterm mask.
// It also flags any combination where fn != ~f. It runs in synthesizable logic
// next to the function instance, so no simulator $monitor is needed.
// PARAMETERS
// N_IN    3  number of function inputs, 1..4; combinations = 2**N_IN
// DWELL   4  clock cycles each combination is held, >= 2
// SETTLE  2  cycle offset within the dwell at which f/fn are sampled, 1..DWELL-1
// PORTS
// clk       in   1          rising-edge clock
// rst       in   1          synchronous, active-high reset
// start     in   1          begin a capture pass, sampled only while idle
// stim      out  N_IN       input combination to the DUT, MSB = x, LSB = z
// f         in   1          DUT true output
// fn        in   1          DUT complement output
// busy      out  1          high while a pass is running
// done      out  1          one-cycle pulse when a pass completes
// minterms  out  2**N_IN    bit i = f sampled while stim == i
// comp_err  out  1          sticky: some sample had fn == f
// err_idx   out  N_IN       stim index of the first complement mismatch
// BEHAVIOUR
// - Reset (rst high at an edge): stim=0, busy=0, done=0, minterms=0, comp_err=0,
//   err_idx=0, FSM=IDLE, idx=0, cnt=0. Reset overrides everything, including mid-pass.
// - Registers: FSM {IDLE, RUN}; idx (N_IN bits); cnt (clog2(DWELL) bits).
// - IDLE: start=1 at an edge moves FSM to RUN. On that same edge:
//   - busy<=1, idx<=0, cnt<=0, stim<=0
//   - minterms<=0, comp_err<=0, err_idx<=0
// - RUN, every edge: cnt increments.
//   - When cnt==SETTLE at an edge, that edge captures the current inputs:
//     minterms[idx]<=f.
//   - At the same edge, if fn==f and comp_err==0: comp_err<=1, err_idx<=idx.
//   - f and fn are ignored on all other cycles; glitches outside the sample edge
//     have no effect.
// - RUN, when cnt==DWELL-1 at an edge:
//   - If idx < 2**N_IN-1: idx<=idx+1, stim<=idx+1, cnt<=0.
//   - Otherwise: FSM<=IDLE, busy<=0, done<=1 for exactly one cycle, stim<=0.
// - stim always equals idx during RUN; it changes only at dwell boundaries.
// - Pass length: 2**N_IN*DWELL cycles of busy. done rises on the edge where busy
//   falls.
// - start while busy is ignored; it is not queued.
// - start asserted in the done cycle: the FSM is already IDLE, so the new pass is
//   accepted and minterms/comp_err are cleared on that edge.
// - minterms, comp_err and err_idx hold their values from done until the next
//   accepted start or rst.
// - comp_err is sticky for the pass; err_idx records only the first mismatch
//   (lowest idx).
// - The idx wrap from 2**N_IN-1 never occurs; the pass ends instead.
// - Widths: idx compares are unsigned; if DWELL is a power of two, cnt never
//   overflows past DWELL-1.
// TESTING (defaults N_IN=3, DWELL=4, SETTLE=2)
// 1. DUT f = x'y'z + x'yz + xy', fn=~f; start pulse -> busy 32 cycles, stim 0..7 every
//    4 cycles, done pulse, minterms=8'h3A, comp_err=0.
// 2. Same DUT but fn forced equal to f while stim==6 -> minterms=8'h3A, comp_err=1,
//    err_idx=3'd6.
// 3. start re-pulsed 10 cycles into the pass -> ignored; done still at cycle 32 from
//    the first start; minterms=8'h3A.
// 4. rst asserted 13 cycles into the pass -> next cycle: all outputs 0, busy=0.
//    A new start then completes normally with 8'h3A.
// 5. f toggled on every cnt!=SETTLE cycle, with correct values on the sample edges
//    -> minterms=8'h3A, comp_err=0.
// 6. start held high through done -> second pass begins on the done edge, minterms
//    reads 0 the next cycle, and the second done comes 32 cycles later.

Source files
------------

// File: rtl/truth_table_capture.sv
// truth_table_capture
// Sweeps every input combination of an N_IN-input function-under-test, holds
// each for DWELL cycles, samples f/fn at cycle offset SETTLE within the dwell,
// rebuilds the minterm mask and flags the first combination where fn == f.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; results from the last pass are held
// ST_RUN   | sweeping stim 0..2**N_IN-1, one dwell per combination
module truth_table_capture #(
  parameter int N_IN   = 3,
  parameter int DWELL  = 4,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      stim,
  input  logic                 f,
  input  logic                 fn,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   minterms,
  output logic                 comp_err,
  output logic [N_IN-1:0]      err_idx
);

  localparam int NCOMB = 2**N_IN;
  localparam int CW    = $clog2(DWELL);

  localparam logic [CW-1:0]   CNT_SAMPLE = CW'(SETTLE);
  localparam logic [CW-1:0]   CNT_LAST   = CW'(DWELL - 1);
  localparam logic [N_IN-1:0] IDX_LAST   = N_IN'(NCOMB - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NCOMB-1:0]  minterms_q, minterms_d;
  logic              comp_err_q, comp_err_d;
  logic [N_IN-1:0]   err_idx_q, err_idx_d;

  // Next-state: start a pass from idle, otherwise step the dwell counter and
  // capture f/fn only on the sample cycle of each dwell.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    stim_d     = stim_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    minterms_d = minterms_q;
    comp_err_d = comp_err_q;
    err_idx_d  = err_idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          busy_d     = 1'b1;
          idx_d      = '0;
          cnt_d      = '0;
          stim_d     = '0;
          minterms_d = '0;
          comp_err_d = 1'b0;
          err_idx_d  = '0;
        end
      end

      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;

        if (cnt_q == CNT_SAMPLE) begin
          minterms_d[idx_q] = f;
          // Only the first mismatch is recorded; later ones just keep the flag set.
          if ((fn == f) && !comp_err_q) begin
            comp_err_d = 1'b1;
            err_idx_d  = idx_q;
          end
        end

        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q != IDX_LAST) begin
            idx_d  = idx_q + 1'b1;
            stim_d = idx_q + 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stim_d  = '0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset wins over any in-flight pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      stim_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      minterms_q <= '0;
      comp_err_q <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      stim_q     <= stim_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      minterms_q <= minterms_d;
      comp_err_q <= comp_err_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign stim     = stim_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign minterms = minterms_q;
  assign comp_err = comp_err_q;
  assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Bench for truth_table_capture: a position-in-pass model predicts every
// output each cycle; directed scenarios plus randomized passes drive it.
module tb_truth_table_capture;

  localparam int N_IN   = 3;
  localparam int DWELL  = 4;
  localparam int SETTLE = 2;
  localparam int NC     = 2**N_IN;
  localparam int TOTAL  = NC * DWELL;

  logic            clk;
  logic            rst;
  logic            start;
  logic [N_IN-1:0] stim;
  logic            f;
  logic            fn;
  logic            busy;
  logic            done;
  logic [NC-1:0]   minterms;
  logic            comp_err;
  logic [N_IN-1:0] err_idx;

  truth_table_capture #(.N_IN(N_IN), .DWELL(DWELL), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stim     (stim),
    .f        (f),
    .fn       (fn),
    .busy     (busy),
    .done     (done),
    .minterms (minterms),
    .comp_err (comp_err),
    .err_idx  (err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus configuration for the current pass.
  logic [NC-1:0] cur_mask;
  logic [NC-1:0] cur_fault;
  bit            glitch;

  // Model: a pass is just "edges since the accepting edge"; everything else is
  // derived from that position with division and modulo.
  bit            m_active;
  int            m_pos;
  bit            m_done;
  logic [NC-1:0] m_min;
  bit            m_err;
  int            m_eidx;

  int n_checks;
  int n_fail;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_pos = 0; m_done = 0; m_min = '0; m_err = 0; m_eidx = 0;
    end else if (m_active) begin
      if ((m_pos % DWELL) == SETTLE) begin
        m_min[m_pos / DWELL] = f;
        if ((fn == f) && !m_err) begin
          m_err  = 1;
          m_eidx = m_pos / DWELL;
        end
      end
      if (m_pos == TOTAL - 1) begin
        m_active = 0;
        m_done   = 1;
      end else begin
        m_pos++;
        m_done = 0;
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_active = 1; m_pos = 0; m_min = '0; m_err = 0; m_eidx = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Drive inputs for one cycle, advance to the next falling edge, then compare
  // every DUT output against the model.
  task automatic cyc(input logic s, input logic r);
    int slot;
    bit samp;
    start = s;
    rst   = r;
    slot  = m_active ? (m_pos / DWELL) : 0;
    samp  = m_active && ((m_pos % DWELL) == SETTLE);
    if (samp || !glitch) begin
      f  = cur_mask[slot];
      fn = (samp && cur_fault[slot]) ? f : ~f;
    end else begin
      f  = 1'($urandom);
      fn = 1'($urandom);
    end
    @(negedge clk);
    chk("busy",     32'(busy),     32'(m_active));
    chk("done",     32'(done),     32'(m_done));
    chk("stim",     32'(stim),     m_active ? 32'(m_pos / DWELL) : 32'd0);
    chk("minterms", 32'(minterms), 32'(m_min));
    chk("comp_err", 32'(comp_err), 32'(m_err));
    chk("err_idx",  32'(err_idx),  32'(m_eidx));
  endtask

  // Runs until done is seen, counting busy cycles; a missing done is a failure.
  task automatic wait_done(input logic s, output int n);
    int k;
    n = 0;
    k = 0;
    while (!done && k < 200) begin
      if (busy) n++;
      cyc(s, 1'b0);
      k++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    n_checks  = 0;
    n_fail    = 0;
    cur_mask  = 8'h3A;
    cur_fault = '0;
    glitch    = 0;
    rst = 1'b1; start = 1'b0; f = 1'b0; fn = 1'b1;

    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_minterms", 32'(minterms), 32'd0);

    // Plain sweep of f = x'y'z + x'yz + xy'.
    cyc(1'b1, 1'b0);
    wait_done(1'b0, n);
    chk("s1_len", 32'(n), 32'd32);
    chk("s1_minterms", 32'(minterms), 32'h3A);
    chk("s1_comp_err", 32'(comp_err), 32'd0);
    cyc(1'b0, 1'b0);
    chk("s1_done_pulse", 32'(done), 32'd0);

    // Complement mismatch at combination 6.
    cur_fault = 8'h40;
    cyc(1'b1, 1'b0);
    wait_done(1'b0, n);
    chk("s2_minterms", 32'(minterms), 32'h3A);
    chk("s2_comp_err", 32'(comp_err), 32'd1);
    chk("s2_err_idx", 32'(err_idx), 32'd6);
    cur_fault = '0;

    // start re-pulsed mid-pass is ignored.
    cyc(1'b1, 1'b0);
    repeat (9) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    wait_done(1'b0, n);
    chk("s3_len", 32'(n + 10), 32'd32);
    chk("s3_minterms", 32'(minterms), 32'h3A);

    // Reset 13 cycles into a pass, then a clean pass.
    cyc(1'b1, 1'b0);
    repeat (12) cyc(1'b0, 1'b0);
    chk("s4_stim_mid", 32'(stim), 32'd3);
    cyc(1'b0, 1'b1);
    chk("s4_rst_busy", 32'(busy), 32'd0);
    chk("s4_rst_stim", 32'(stim), 32'd0);
    chk("s4_rst_minterms", 32'(minterms), 32'd0);
    cyc(1'b1, 1'b0);
    wait_done(1'b0, n);
    chk("s4_minterms", 32'(minterms), 32'h3A);

    // Glitching f/fn outside the sample edge must not matter.
    glitch = 1;
    cyc(1'b1, 1'b0);
    wait_done(1'b0, n);
    chk("s5_minterms", 32'(minterms), 32'h3A);
    chk("s5_comp_err", 32'(comp_err), 32'd0);
    glitch = 0;

    // start held through done starts a second pass on the following edge.
    cyc(1'b1, 1'b0);
    wait_done(1'b1, n);
    cyc(1'b1, 1'b0);
    chk("s6_busy_again", 32'(busy), 32'd1);
    chk("s6_minterms_clr", 32'(minterms), 32'd0);
    wait_done(1'b0, n);
    chk("s6_len", 32'(n), 32'd32);

    // Randomized passes, occasionally with a reset dropped in mid-pass.
    for (int p = 0; p < 10; p++) begin
      cur_mask  = NC'($urandom);
      cur_fault = ($urandom_range(0, 1) == 1) ? NC'($urandom & $urandom) : '0;
      glitch    = 1'($urandom);
      cyc(1'b1, 1'b0);
      if (p == 4) begin
        repeat ($urandom_range(1, 30)) cyc(1'($urandom), 1'b0);
        cyc(1'b0, 1'b1);
        chk("rnd_rst_busy", 32'(busy), 32'd0);
        cyc(1'b1, 1'b0);
      end
      wait_done(1'($urandom_range(0, 3) == 0), n);
      chk("rnd_minterms", 32'(minterms), 32'(cur_mask));
      chk("rnd_comp_err", 32'(comp_err), 32'(cur_fault != '0));
      cyc(1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
